// File: rtl/tmr_scrub_pkg.sv
// tmr_scrub_pkg: shared state type and error-counter constants for the TMR scrubber
package tmr_scrub_pkg;
    typedef enum logic [1:0] {IDLE, READ, VOTE, WRBK} scrubState_e;
    localparam int ERRCNT_W = 16;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = '1;
endpackage

// File: rtl/tmr_majority_voter.sv
// tmr_majority_voter: bitwise two-of-three vote with per-copy mismatch mask
module tmr_majority_voter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic [2:0]       mask,
    output logic             uncorr
);
    // mask bit set for each copy that disagrees with the voted word; uncorr when no two copies agree
    always_comb begin
        voted  = (a & b) | (b & c) | (a & c);
        mask   = {c != voted, b != voted, a != voted};
        uncorr = (a != b) && (b != c) && (a != c);
    end
endmodule

// File: rtl/tmr_scrub_ctrl.sv
// tmr_scrub_ctrl: periodic scrubber and user-priority port arbiter for a triplicated bank
module tmr_scrub_ctrl
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int INTERVAL = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scrub_en,
    input  logic                     user_we,
    input  logic [$clog2(DEPTH)-1:0] user_addr,
    input  logic [WIDTH-1:0]         user_wdata,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [2:0]               mem_we,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdataA,
    input  logic [WIDTH-1:0]         mem_rdataB,
    input  logic [WIDTH-1:0]         mem_rdataC,
    output logic                     busy,
    output logic                     err_flag,
    output logic                     uncorr_flag,
    output logic [ERRCNT_W-1:0]      err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(INTERVAL);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(INTERVAL - 1);

    scrubState_e      state, stateNext;
    logic [AW-1:0]    scanAddr;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] votedNow, votedQ, curVoted;
    logic [2:0]       maskNow, maskQ, curMask;
    logic             uncorrNow, uncorrQ, curUncorr, heldQ;
    logic             inVote, correctable, collide, advance;

    tmr_majority_voter #(.WIDTH(WIDTH)) voter (
        .a      (mem_rdataA),
        .b      (mem_rdataB),
        .c      (mem_rdataC),
        .voted  (votedNow),
        .mask   (maskNow),
        .uncorr (uncorrNow)
    );

    // a user write stalling VOTE clobbers the next read data, so the vote is held across the stall
    always_comb begin
        curVoted    = heldQ ? votedQ : votedNow;
        curMask     = heldQ ? maskQ : maskNow;
        curUncorr   = heldQ ? uncorrQ : uncorrNow;
        inVote      = !user_we && state == VOTE;
        correctable = curMask != 3'b000 && !curUncorr;
        collide     = user_we && user_addr == scanAddr && (state == VOTE || state == WRBK);
        advance     = !user_we && ((state == VOTE && !correctable) || state == WRBK);
        stateNext   = state;
        if (collide)
            stateNext = READ;
        else if (advance)
            stateNext = (&scanAddr || !scrub_en) ? IDLE : READ;
        else if (!user_we) begin
            if (state == IDLE && scrub_en && timer == '0)
                stateNext = READ;
            else if (state == READ)
                stateNext = VOTE;
            else if (state == VOTE)
                stateNext = WRBK;
        end
    end

    // user write owns the bank port; otherwise the scrubber drives it; everything quiet in reset
    always_comb begin
        mem_addr  = '0;
        mem_we    = 3'b000;
        mem_wdata = '0;
        busy      = 1'b0;
        if (!rst) begin
            busy = state != IDLE;
            if (user_we) begin
                mem_addr  = user_addr;
                mem_we    = 3'b111;
                mem_wdata = user_wdata;
            end else if (state != IDLE) begin
                mem_addr = scanAddr;
                if (state == WRBK) begin
                    mem_we    = maskQ;
                    mem_wdata = votedQ;
                end
            end
        end
    end

    // state, scan pointer, interval timer, latched vote and registered statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            scanAddr    <= '0;
            timer       <= TIMER_LOAD;
            votedQ      <= '0;
            maskQ       <= 3'b000;
            uncorrQ     <= 1'b0;
            heldQ       <= 1'b0;
            err_flag    <= 1'b0;
            uncorr_flag <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= stateNext;
            err_flag    <= inVote && correctable;
            uncorr_flag <= inVote && curUncorr;
            if (inVote && correctable && err_count != ERRCNT_MAX)
                err_count <= err_count + 1'b1;
            if (advance)
                scanAddr <= scanAddr + 1'b1;
            if (!user_we && state == IDLE && scrub_en)
                timer <= (timer == '0) ? TIMER_LOAD : timer - 1'b1;
            if (state == VOTE) begin
                votedQ  <= curVoted;
                maskQ   <= curMask;
                uncorrQ <= curUncorr;
            end
            heldQ <= state == VOTE && user_we && !collide;
        end
    end
endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// tb_tmr_scrub_ctrl: scoreboard bench with a triplicated bank model and fault injection
module tb_tmr_scrub_ctrl;
    localparam int WIDTH    = 8;
    localparam int DEPTH    = 16;
    localparam int INTERVAL = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scrub_en = 1'b0;
    logic        user_we = 1'b0;
    logic [3:0]  user_addr = '0;
    logic [7:0]  user_wdata = '0;
    logic [3:0]  mem_addr;
    logic [2:0]  mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdataA, mem_rdataB, mem_rdataC;
    logic        busy, err_flag, uncorr_flag;
    logic [15:0] err_count;

    logic [7:0]  memA [DEPTH] = '{default: 8'h00};
    logic [7:0]  memB [DEPTH] = '{default: 8'h00};
    logic [7:0]  memC [DEPTH] = '{default: 8'h00};
    logic        pokeEn = 1'b0;
    logic [2:0]  pokeMask = '0;
    logic [3:0]  pokeAddr = '0;
    logic [7:0]  pokeData = '0;

    logic [15:0] obsLog [1024];
    int          obsWr = 0, obsRd = 0, errPulses = 0, uncorrPulses = 0;
    logic [15:0] expQ [$];
    logic [15:0] expCount = '0;
    int          checks = 0, passed = 0;

    tmr_scrub_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INTERVAL(INTERVAL)) dut (
        .clk         (clk),
        .rst         (rst),
        .scrub_en    (scrub_en),
        .user_we     (user_we),
        .user_addr   (user_addr),
        .user_wdata  (user_wdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdataA  (mem_rdataA),
        .mem_rdataB  (mem_rdataB),
        .mem_rdataC  (mem_rdataC),
        .busy        (busy),
        .err_flag    (err_flag),
        .uncorr_flag (uncorr_flag),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // triplicated bank: registered read, per-copy write, plus a fault-injection port
    always @(posedge clk) begin
        mem_rdataA <= memA[mem_addr];
        mem_rdataB <= memB[mem_addr];
        mem_rdataC <= memC[mem_addr];
        if (mem_we[0]) memA[mem_addr] <= mem_wdata;
        if (mem_we[1]) memB[mem_addr] <= mem_wdata;
        if (mem_we[2]) memC[mem_addr] <= mem_wdata;
        if (pokeEn && pokeMask[0]) memA[pokeAddr] <= pokeData;
        if (pokeEn && pokeMask[1]) memB[pokeAddr] <= pokeData;
        if (pokeEn && pokeMask[2]) memC[pokeAddr] <= pokeData;
    end

    // monitor: log every bank write with the concurrent err_flag, and count flag pulses
    always @(negedge clk) begin
        if (mem_we != 3'b000) begin
            obsLog[obsWr % 1024] = {err_flag, mem_we, mem_addr, mem_wdata};
            obsWr++;
        end
        errPulses    += int'(err_flag);
        uncorrPulses += int'(uncorr_flag);
    end

    task automatic poke(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        pokeEn = 1'b1; pokeMask = m; pokeAddr = a; pokeData = d;
        @(posedge clk); #1;
        pokeEn = 1'b0;
    endtask

    task automatic waitBusy(output int n);
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!busy && n < 2000);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; scrub_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, mem_wdata, busy, err_flag, uncorr_flag} !== 18'h0)
            $display("FAIL reset_outputs got=%h expected=0", {mem_addr, mem_we, mem_wdata, busy, err_flag, uncorr_flag});
        else passed++;
        checks++;
        if (err_count !== 16'h0) $display("FAIL reset_count got=%h expected=0000", err_count); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_clean_sweep;
        int n, m;
        waitBusy(n);
        checks++;
        if (n !== INTERVAL) $display("FAIL clean_start got=%0d expected=%0d", n, INTERVAL); else passed++;
        countBusy(m);
        checks++;
        if (m !== 2 * DEPTH) $display("FAIL clean_busy got=%0d expected=%0d", m, 2 * DEPTH); else passed++;
        repeat (2) @(posedge clk);
        checks++;
        if (obsWr != obsRd) $display("FAIL clean_no_writes got=%0d expected=0", obsWr - obsRd); else passed++;
        obsRd = obsWr;
        checks++;
        if (err_count !== expCount) $display("FAIL clean_count got=%h expected=%h", err_count, expCount); else passed++;
    endtask

    task automatic test_correctable;
        int n, m, eBase;
        logic [15:0] e, g;
        poke(3'b101, 4'd5, 8'hA5);
        poke(3'b010, 4'd5, 8'h5A);
        expQ.push_back({1'b1, 3'b010, 4'd5, 8'hA5});
        expCount++;
        eBase = errPulses;
        waitBusy(n);
        countBusy(m);
        repeat (2) @(posedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            g = (obsRd < obsWr) ? obsLog[obsRd % 1024] : 16'hxxxx;
            obsRd++;
            checks++;
            if (g !== e) $display("FAIL corr_write got=%h expected=%h", g, e); else passed++;
        end
        checks++;
        if (obsRd != obsWr) $display("FAIL corr_extra_writes got=%0d expected=%0d", obsWr, obsRd); else passed++;
        obsRd = obsWr;
        checks++;
        if (errPulses - eBase !== 1) $display("FAIL corr_pulses got=%0d expected=1", errPulses - eBase); else passed++;
        checks++;
        if (err_count !== expCount) $display("FAIL corr_count got=%h expected=%h", err_count, expCount); else passed++;
        checks++;
        if (m !== 2 * DEPTH + 1) $display("FAIL corr_busy got=%0d expected=%0d", m, 2 * DEPTH + 1); else passed++;
    endtask

    task automatic test_uncorrectable;
        int n, m, eBase, uBase;
        logic [15:0] e, g;
        poke(3'b001, 4'd3, 8'h01);
        poke(3'b010, 4'd3, 8'h02);
        poke(3'b100, 4'd3, 8'h04);
        eBase = errPulses; uBase = uncorrPulses;
        waitBusy(n);
        countBusy(m);
        repeat (2) @(posedge clk);
        checks++;
        if (m !== 2 * DEPTH) $display("FAIL uncorr_busy got=%0d expected=%0d", m, 2 * DEPTH); else passed++;
        checks++;
        if (obsWr != obsRd) $display("FAIL uncorr_no_writes got=%0d expected=0", obsWr - obsRd); else passed++;
        obsRd = obsWr;
        checks++;
        if (uncorrPulses - uBase !== 1) $display("FAIL uncorr_pulses got=%0d expected=1", uncorrPulses - uBase); else passed++;
        checks++;
        if (errPulses - eBase !== 0) $display("FAIL uncorr_err_pulses got=%0d expected=0", errPulses - eBase); else passed++;
        checks++;
        if (err_count !== expCount) $display("FAIL uncorr_count got=%h expected=%h", err_count, expCount); else passed++;
        @(posedge clk); #1;
        user_we = 1'b1; user_addr = 4'd3; user_wdata = 8'h00;
        expQ.push_back({1'b0, 3'b111, 4'd3, 8'h00});
        @(posedge clk); #1;
        user_we = 1'b0;
        repeat (2) @(posedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            g = (obsRd < obsWr) ? obsLog[obsRd % 1024] : 16'hxxxx;
            obsRd++;
            checks++;
            if (g !== e) $display("FAIL repair_write got=%h expected=%h", g, e); else passed++;
        end
        checks++;
        if (obsRd != obsWr) $display("FAIL repair_extra_writes got=%0d expected=%0d", obsWr, obsRd); else passed++;
        obsRd = obsWr;
    endtask

    task automatic test_collision;
        int n, m, eBase;
        logic [15:0] e, g;
        poke(3'b101, 4'd7, 8'h11);
        poke(3'b010, 4'd7, 8'h99);
        eBase = errPulses;
        waitBusy(n);
        repeat (15) @(posedge clk);
        #1;
        user_we = 1'b1; user_addr = 4'd7; user_wdata = 8'h3C;
        expQ.push_back({1'b0, 3'b111, 4'd7, 8'h3C});
        @(posedge clk); #1;
        user_we = 1'b0;
        @(negedge clk);
        countBusy(m);
        repeat (2) @(posedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            g = (obsRd < obsWr) ? obsLog[obsRd % 1024] : 16'hxxxx;
            obsRd++;
            checks++;
            if (g !== e) $display("FAIL coll_write got=%h expected=%h", g, e); else passed++;
        end
        checks++;
        if (obsRd != obsWr) $display("FAIL coll_extra_writes got=%0d expected=%0d", obsWr, obsRd); else passed++;
        obsRd = obsWr;
        checks++;
        if (errPulses - eBase !== 0) $display("FAIL coll_pulses got=%0d expected=0", errPulses - eBase); else passed++;
        checks++;
        if (err_count !== expCount) $display("FAIL coll_count got=%h expected=%h", err_count, expCount); else passed++;
        checks++;
        if (16 + m !== 2 * DEPTH + 2) $display("FAIL coll_busy got=%0d expected=%0d", 16 + m, 2 * DEPTH + 2); else passed++;
    endtask

    task automatic test_scrub_disable;
        int n, m, hits;
        waitBusy(n);
        repeat (18) @(posedge clk);
        #1;
        scrub_en = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== 4'd9) $display("FAIL dis_addr got=%0d expected=9", mem_addr); else passed++;
        countBusy(m);
        checks++;
        if (18 + m !== 20) $display("FAIL dis_busy got=%0d expected=20", 18 + m); else passed++;
        hits = 0;
        repeat (50) begin
            @(negedge clk);
            hits += int'(busy);
        end
        checks++;
        if (hits !== 0) $display("FAIL dis_idle got=%0d expected=0", hits); else passed++;
        @(posedge clk); #1;
        scrub_en = 1'b1;
        waitBusy(n);
        checks++;
        if (n !== INTERVAL) $display("FAIL resume_start got=%0d expected=%0d", n, INTERVAL); else passed++;
        checks++;
        if (mem_addr !== 4'd10) $display("FAIL resume_addr got=%0d expected=10", mem_addr); else passed++;
        countBusy(m);
        checks++;
        if (m !== 12) $display("FAIL resume_busy got=%0d expected=12", m); else passed++;
    endtask

    task automatic test_saturation;
        int n, m, eBase;
        logic [15:0] e, g;
        @(posedge clk); #1;
        force dut.err_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.err_count;
        poke(3'b001, 4'd2, 8'h77);
        poke(3'b100, 4'd12, 8'h10);
        expQ.push_back({1'b1, 3'b001, 4'd2, 8'h00});
        expQ.push_back({1'b1, 3'b100, 4'd12, 8'h00});
        expCount = 16'hFFFF;
        eBase = errPulses;
        waitBusy(n);
        countBusy(m);
        repeat (2) @(posedge clk);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            g = (obsRd < obsWr) ? obsLog[obsRd % 1024] : 16'hxxxx;
            obsRd++;
            checks++;
            if (g !== e) $display("FAIL sat_write got=%h expected=%h", g, e); else passed++;
        end
        checks++;
        if (obsRd != obsWr) $display("FAIL sat_extra_writes got=%0d expected=%0d", obsWr, obsRd); else passed++;
        obsRd = obsWr;
        checks++;
        if (errPulses - eBase !== 2) $display("FAIL sat_pulses got=%0d expected=2", errPulses - eBase); else passed++;
        checks++;
        if (err_count !== expCount) $display("FAIL sat_count got=%h expected=%h", err_count, expCount); else passed++;
        checks++;
        if (m !== 2 * DEPTH + 2) $display("FAIL sat_busy got=%0d expected=%0d", m, 2 * DEPTH + 2); else passed++;
    endtask

    task automatic test_reset_wrbk;
        int n;
        poke(3'b010, 4'd4, 8'h40);
        waitBusy(n);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, mem_wdata, busy} !== 16'h0)
            $display("FAIL rst_wrbk_port got=%h expected=0", {mem_addr, mem_we, mem_wdata, busy});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_addr, mem_we, mem_wdata, busy, err_flag, uncorr_flag} !== 18'h0)
            $display("FAIL rst_after_outputs got=%h expected=0", {mem_addr, mem_we, mem_wdata, busy, err_flag, uncorr_flag});
        else passed++;
        checks++;
        if (err_count !== 16'h0) $display("FAIL rst_after_count got=%h expected=0000", err_count); else passed++;
        repeat (2) @(posedge clk);
        checks++;
        if (obsWr != obsRd) $display("FAIL rst_no_writes got=%0d expected=0", obsWr - obsRd); else passed++;
        obsRd = obsWr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clean_sweep();
        test_correctable();
        test_uncorrectable();
        test_collision();
        test_scrub_disable();
        test_saturation();
        test_reset_wrbk();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/tmr_scrub_ctrl.md
# tmr_scrub_ctrl

Background scrubber and port arbiter for a triplicated register bank (copies A/B/C) built from fanned-out, majority-voted storage. On a programmable interval it walks every address, reads all three copies, votes bitwise, and writes the voted word back into any copy that disagrees. User writes share the same bank port and always win. It sits between the user-side write interface and the triplicated storage, and reports upset statistics to the slow-control block.

## Interface
- WIDTH, 8, data word width
- DEPTH, 16, number of words; power of two, ≥2
- INTERVAL, 256, idle cycles between sweep starts; ≥2
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- scrub_en  in  1  enables interval timer and sweeps
- user_we  in  1  user write strobe, single cycle
- user_addr  in  log2(DEPTH)  user write address
- user_wdata  in  WIDTH  user write data
- mem_addr  out  log2(DEPTH)  bank address, shared by all copies
- mem_we  out  3  per-copy write enable {C,B,A}
- mem_wdata  out  WIDTH  write data to all copies
- mem_rdataA / mem_rdataB / mem_rdataC  in  WIDTH each  registered read data, valid one cycle after mem_addr
- busy  out  1  sweep in progress
- err_flag  out  1  one-cycle pulse: correctable mismatch found
- uncorr_flag  out  1  one-cycle pulse: all three copies pairwise differ in some bit position where no majority exists (impossible bitwise; defined here as A≠B, B≠C, A≠C)
- err_count  out  16  saturating count of corrected words

## Operation
- States: IDLE, READ, VOTE, WRBK.
- IDLE: timer counts down from INTERVAL-1 only while scrub_en=1; holds otherwise. At 0 with scrub_en=1 → READ, timer reloads.
- READ: drive mem_addr=scan_addr, mem_we=000 → VOTE.
- VOTE: voted=maj(A,B,C) bitwise; bad mask bit i set when copy i ≠ voted.
  - mask=000 → advance.
  - all three pairwise different → pulse uncorr_flag, no writeback, advance.
  - else → pulse err_flag, err_count+1 (sticks at 0xFFFF), latch voted and mask → WRBK.
- WRBK: mem_addr=scan_addr, mem_wdata=voted, mem_we=mask → advance.
- Advance: scan_addr+1 (wraps DEPTH-1→0). If wrapped to 0 or scrub_en=0 → IDLE (scan_addr kept, next sweep resumes there), else → READ.
- busy=1 in READ/VOTE/WRBK.
- Arbitration: user_we=1 overrides the port that cycle: mem_addr=user_addr, mem_wdata=user_wdata, mem_we=111. FSM state, timer and flags freeze (no transition, no pulse).
- Collision: user write to scan_addr while state is VOTE or WRBK → discard the latched vote and return to READ for the same address. No count or flag for that attempt.
- Reset: state IDLE, scan_addr 0, timer INTERVAL-1, err_count 0, all outputs 0 (mem_addr 0, mem_we 000, mem_wdata 0, busy 0, pulses 0). Reset mid-sweep abandons the sweep; no write is issued in the reset cycle.

## Timing
- Port outputs are combinational from the state/user mux; flags and err_count are registered. err_flag, uncorr_flag and the err_count update appear the cycle after VOTE.
- Per word: 2 cycles when clean, 3 cycles with writeback, +1 per stalling user write.
- Full clean sweep: 2·DEPTH cycles (32 at defaults). The first sweep starts INTERVAL cycles after reset release with scrub_en=1.
- A user write and scrub writeback never occur in the same cycle.

## Structure
- Package tmr_scrub_pkg: state enum, ERRCNT_W=16, and the ERRCNT_MAX saturation constant.
- Sub-module tmr_majority_voter (combinational, WIDTH-parameterised): inputs A/B/C; outputs voted word, 3-bit mismatch mask, uncorrectable flag. The scrubber instantiates it once on mem_rdata.

## Test plan
- Clean bank, scrub_en=1 after reset: sweep starts at cycle 256. busy high for exactly 32 cycles. No mem_we activity. err_count=0.
- Copy B at addr 5 = 0x5A, A=C=0xA5: one WRBK with mem_addr=5, mem_we=010, mem_wdata=0xA5. One err_flag pulse. err_count=1.
- Addr 3 with A=0x01, B=0x02, C=0x04: uncorr_flag pulses once, no write, err_count unchanged.
- User write addr 7 = 0x3C while FSM is in VOTE on addr 7 with B corrupted: the user write issues with mem_we=111. FSM re-reads addr 7, finds it clean, and issues no WRBK and no err_flag.
- scrub_en dropped mid-sweep at addr 9: the FSM finishes the word and goes IDLE. Re-enabled, the next sweep starts at addr 10 after INTERVAL cycles.
- err_count preloaded to 0xFFFF via repeated faults: a further fault leaves it at 0xFFFF. rst asserted during WRBK: next cycle IDLE, all outputs 0.
